// File: rtl/alu_share_ctrl.sv
// Shares one 32-bit ALU between two requesters: arbitrate, latch, execute, respond.
// Optional sticky overflow flag with clear input when ALU_SHARE_STICKY_V_EN is defined.
module alu_share_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [2:0]  gin0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [2:0]  gin1,
`ifdef ALU_SHARE_STICKY_V_EN
  input  logic        clr_v,
  output logic        v_sticky,
`endif
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic [2:0]  status,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  gin_q, gin_d;
  logic        prio_q, prio_d;  // 1: port 1 wins the next conflict
  logic [31:0] result_q, result_d;
  logic [2:0]  status_q, status_d;
  logic        err_q, err_d;

  logic [31:0] alu_sum;
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic        add_v;
  logic        sub_v;
  logic        alu_v;
  logic        alu_illegal;
  logic        pick1;

  // ALU datapath, driven only from the latched operands
  always_comb begin
    add_res     = a_q + b_q;
    sub_res     = a_q - b_q;
    add_v       = (a_q[31] == b_q[31]) && (add_res[31] != a_q[31]);
    sub_v       = (a_q[31] != b_q[31]) && (sub_res[31] != a_q[31]);
    alu_sum     = '0;
    alu_v       = 1'b0;
    alu_illegal = 1'b0;
    unique case (gin_q)
      3'b010: begin alu_sum = add_res;           alu_v = add_v; end
      3'b110: begin alu_sum = sub_res;           alu_v = sub_v; end
      3'b111: begin alu_sum = {31'b0, sub_res[31]}; alu_v = sub_v; end
      3'b000: alu_sum = a_q & b_q;
      3'b001: alu_sum = a_q | b_q;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign pick1 = req1 && (!req0 || (RR_EN && prio_q));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    a_d      = a_q;
    b_d      = b_q;
    gin_d    = gin_q;
    prio_d   = prio_q;
    result_d = result_q;
    status_d = status_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          gin_d   = pick1 ? gin1 : gin0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (alu_illegal) begin
          result_d = '0;
          status_d = 3'b010;
          err_d    = 1'b1;
        end else begin
          result_d = alu_sum;
          status_d = {alu_sum[31], alu_sum == 32'd0, alu_v};
          err_d    = 1'b0;
        end
        state_d = StResp;
      end
      StResp: begin
        done_d  = gnt_q;
        prio_d  = gnt_q[0];
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      gin_q    <= '0;
      prio_q   <= 1'b0;
      result_q <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gin_q    <= gin_d;
      prio_q   <= prio_d;
      result_q <= result_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

`ifdef ALU_SHARE_STICKY_V_EN
  logic v_sticky_q, v_sticky_d;

  // Set has priority over clear
  always_comb begin
    v_sticky_d = v_sticky_q;
    if (clr_v) v_sticky_d = 1'b0;
    if ((state_q == StResp) && status_q[0]) v_sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) v_sticky_q <= 1'b0;
    else       v_sticky_q <= v_sticky_d;
  end

  assign v_sticky = v_sticky_q;
`endif

  assign gnt    = gnt_q;
  assign busy   = (state_q != StIdle);
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign result = result_q;
  assign status = status_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0]  gin0 = '0, gin1 = '0;
  logic        clr_v = 1'b0;
  logic        v_sticky, v_sticky_fp;
  logic [1:0]  gnt, gnt_fp;
  logic        busy, busy_fp, done0, done1, done0_fp, done1_fp, err, err_fp;
  logic [31:0] result, result_fp;
  logic [2:0]  status, status_fp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .gin0(gin0),
    .req1(req1), .a1(a1), .b1(b1), .gin1(gin1),
`ifdef ALU_SHARE_STICKY_V_EN
    .clr_v(clr_v), .v_sticky(v_sticky),
`endif
    .gnt(gnt), .busy(busy), .done0(done0), .done1(done1),
    .result(result), .status(status), .err(err)
  );

  alu_share_ctrl #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .gin0(gin0),
    .req1(req1), .a1(a1), .b1(b1), .gin1(gin1),
`ifdef ALU_SHARE_STICKY_V_EN
    .clr_v(clr_v), .v_sticky(v_sticky_fp),
`endif
    .gnt(gnt_fp), .busy(busy_fp), .done0(done0_fp), .done1(done1_fp),
    .result(result_fp), .status(status_fp), .err(err_fp)
  );

`ifndef ALU_SHARE_STICKY_V_EN
  assign v_sticky    = 1'b0;
  assign v_sticky_fp = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Raise one request, wait (bounded) for any done, then drop the request.
  task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] g, output int lat, output logic [31:0] r,
                        output logic [2:0] st, output logic e, output logic [1:0] dn);
    if (port == 0) begin req0 = 1'b1; a0 = a; b0 = b; gin0 = g; end
    else           begin req1 = 1'b1; a1 = a; b1 = b; gin1 = g; end
    lat = 0; r = '0; st = '0; e = 1'b0; dn = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (done0 || done1) begin
        lat = i; dn = {done1, done0}; r = result; st = status; e = err;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({gnt, busy, done0, done1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got gnt/busy/done=%b required 00000", {gnt, busy, done0, done1});
    end
    n_tests++;
    if ({result, status, err} !== 36'b0) begin
      n_fail++;
      $display("FAIL reset_data: got result=%h status=%b err=%b required 0/000/0",
               result, status, err);
    end
  endtask

  task automatic test_add();
    do_reset();
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd5; gin0 = 3'b010;
    tick();
    n_tests++;
    if ({gnt, busy, done0} !== 4'b0110) begin
      n_fail++;
      $display("FAIL add_exec: got gnt/busy/done0=%b required 0110", {gnt, busy, done0});
    end
    tick();
    n_tests++;
    if ({gnt, busy, done0} !== 4'b0110) begin
      n_fail++;
      $display("FAIL add_resp: got gnt/busy/done0=%b required 0110", {gnt, busy, done0});
    end
    tick();
    n_tests++;
    if ({done0, done1, result, status, err} !== {2'b10, 32'd12, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL add_done: got done=%b%b result=%0d status=%b err=%b required 10/12/000/0",
               done0, done1, result, status, err);
    end
    req0 = 1'b0;
    tick();
    n_tests++;
    if ({gnt, busy, done0, result} !== {2'b00, 1'b0, 1'b0, 32'd12}) begin
      n_fail++;
      $display("FAIL add_after: got gnt=%b busy=%b done0=%b result=%0d required 00/0/0/12",
               gnt, busy, done0, result);
    end
  endtask

  task automatic test_sub_ovf();
    int lat; logic [31:0] r; logic [2:0] st; logic e; logic [1:0] dn;
    do_reset();
    run_op(1, 32'h8000_0000, 32'd1, 3'b110, lat, r, st, e, dn);
    n_tests++;
    if (lat !== 3 || dn !== 2'b10) begin
      n_fail++;
      $display("FAIL sub_latency: got lat=%0d done=%b required 3/10", lat, dn);
    end
    n_tests++;
    if ({r, st, e} !== {32'h7FFF_FFFF, 3'b001, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_ovf: got result=%h status=%b err=%b required 7fffffff/001/0", r, st, e);
    end
`ifdef ALU_SHARE_STICKY_V_EN
    tick();
    n_tests++;
    if (v_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_hold: got v_sticky=%b required 1", v_sticky);
    end
    clr_v = 1'b1;
    tick();
    clr_v = 1'b0;
    n_tests++;
    if (v_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clr: got v_sticky=%b required 0", v_sticky);
    end
`endif
  endtask

  task automatic test_slt();
    int lat; logic [31:0] r; logic [2:0] st; logic e; logic [1:0] dn;
    do_reset();
    run_op(0, 32'd3, 32'd5, 3'b111, lat, r, st, e, dn);
    n_tests++;
    if ({r, st, e} !== {32'd1, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL slt_lt: got result=%h status=%b err=%b required 1/000/0", r, st, e);
    end
    tick();
    run_op(0, 32'd5, 32'd3, 3'b111, lat, r, st, e, dn);
    n_tests++;
    if ({r, st, e} !== {32'd0, 3'b010, 1'b0}) begin
      n_fail++;
      $display("FAIL slt_ge: got result=%h status=%b err=%b required 0/010/0", r, st, e);
    end
    tick();
    run_op(1, 32'h0000_00F0, 32'h0000_000F, 3'b001, lat, r, st, e, dn);
    n_tests++;
    if ({dn, r, st} !== {2'b10, 32'h0000_00FF, 3'b000}) begin
      n_fail++;
      $display("FAIL or_op: got done=%b result=%h status=%b required 10/000000ff/000", dn, r, st);
    end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] r; logic [2:0] st; logic e; logic [1:0] dn;
    do_reset();
    run_op(0, 32'd9, 32'd4, 3'b011, lat, r, st, e, dn);
    n_tests++;
    if (lat !== 3 || {dn, r, st, e} !== {2'b01, 32'd0, 3'b010, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal: got lat=%0d done=%b result=%h status=%b err=%b required 3/01/0/010/1",
               lat, dn, r, st, e);
    end
    tick();
    run_op(0, 32'd2, 32'd2, 3'b010, lat, r, st, e, dn);
    n_tests++;
    if ({r, st, e} !== {32'd4, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_next: got result=%0d status=%b err=%b required 4/000/0", r, st, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  seq_port [4];
    logic [31:0] seq_res [4];
    logic [1:0]  exp_port [4];
    logic [31:0] exp_res [4];
    int ndone = 0;
    int fp0 = 0;
    int fp1 = 0;
    exp_port = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_res  = '{32'd2, 32'd1, 32'd2, 32'd1};
    do_reset();
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; gin0 = 3'b010;
    req1 = 1'b1; a1 = 32'd3; b1 = 32'd1; gin1 = 3'b000;
    for (int i = 0; i < 12; i++) begin
      tick();
      if ((done0 || done1) && ndone < 4) begin
        seq_port[ndone] = {done1, done0};
        seq_res[ndone]  = result;
        ndone++;
      end
      if (done0_fp) fp0++;
      if (done1_fp) fp1++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    n_tests++;
    if (ndone !== 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d dones required 4", ndone);
    end
    for (int k = 0; k < ndone; k++) begin
      n_tests++;
      if (seq_port[k] !== exp_port[k] || seq_res[k] !== exp_res[k]) begin
        n_fail++;
        $display("FAIL rr_seq%0d: got done=%b result=%0d required %b/%0d",
                 k, seq_port[k], seq_res[k], exp_port[k], exp_res[k]);
      end
    end
    n_tests++;
    if (fp0 !== 4 || fp1 !== 0) begin
      n_fail++;
      $display("FAIL fixed_prio: got done0 x%0d done1 x%0d required 4/0", fp0, fp1);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] r; logic [2:0] st; logic e; logic [1:0] dn;
    // No reset first: result still holds the previous test's value
    tick();
    tick();
    req1 = 1'b1; a1 = 32'd10; b1 = 32'd20; gin1 = 3'b010;
    tick();
    n_tests++;
    if ({gnt, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL mid_exec: got gnt=%b busy=%b required 10/1", gnt, busy);
    end
    reset = 1'b1;
    req1 = 1'b0;
    tick();
    reset = 1'b0;
    n_tests++;
    if ({gnt, busy, done1, result} !== {2'b00, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL mid_abort: got gnt=%b busy=%b done1=%b result=%h required 00/0/0/0",
               gnt, busy, done1, result);
    end
    tick();
    tick();
    n_tests++;
    if (done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_nodone: got done1=%b required 0", done1);
    end
    run_op(1, 32'd10, 32'd20, 3'b010, lat, r, st, e, dn);
    n_tests++;
    if (lat !== 3 || {dn, r, st, e} !== {2'b10, 32'd30, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_retry: got lat=%0d done=%b result=%0d status=%b err=%b required 3/10/30/000/0",
               lat, dn, r, st, e);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_ovf();
    test_slt();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
